vga_sync_gen: RTL and testbench

Display timing generator that consumes the one-in-four pixel strobe produced by the clock divider on the 100 MHz system clock. Produces hsync/vsync, an active-video flag, pixel coordinates and line/frame start strobes for the sprite renderer and VGA output pins. Runs 640x480@60 timing by default. Everything runs on `clk`; the pixel rate is expressed only through the `pix_en` clock enable, never as a derived clock.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_axis_counter.sv | 59 +++++
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 display timing constants shared by the VGA sync generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W_DEF    = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END_DEF   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END_DEF   = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter with enable, wrap pulse and
// registered sync/active decode of the position being entered.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned TOTAL      = H_TOTAL_DEF,
    parameter int unsigned ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned SYNC_END   = H_SYNC_END_DEF,
    parameter logic        SYNC_POL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic             wrap_o,
    output logic [CNT_W-1:0] pos_o,
    output logic             sync_o,
    output logic             active_o
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_END);
    localparam logic [CNT_W:0]   ACT     = (CNT_W+1)'(ACTIVE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pos_q;
    logic             sync_q, active_q;
    logic             in_sync;

    always_comb begin
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        in_sync = (cnt_d >= SYNC_LO) && (cnt_d <= SYNC_HI);
    end

    assign wrap_o = en_i && (cnt_q == LAST);

    // cnt_q parks on the last position in reset so the first enable lands on 0,
    // while the visible position register reports 0 from reset onward.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= LAST;
            pos_q    <= '0;
            sync_q   <= ~SYNC_POL;
            active_q <= 1'b0;
        end else if (en_i) begin
            cnt_q    <= cnt_d;
            pos_q    <= cnt_d;
            sync_q   <= in_sync ? SYNC_POL : ~SYNC_POL;
            active_q <= ({1'b0, cnt_d} < ACT);
        end
    end

    assign pos_o    = pos_q;
    assign sync_o   = sync_q;
    assign active_o = active_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator on a pixel clock enable; frame counter output is built
// only when VGA_FRAME_CNT_EN is defined.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam logic [CNT_W:0] H_TOTAL_W = (CNT_W+1)'(H_ACTIVE) + (CNT_W+1)'(H_FP)
                                         + (CNT_W+1)'(H_SYNC) + (CNT_W+1)'(H_BP);
    localparam logic [CNT_W:0] V_TOTAL_W = (CNT_W+1)'(V_ACTIVE) + (CNT_W+1)'(V_FP)
                                         + (CNT_W+1)'(V_SYNC) + (CNT_W+1)'(V_BP);
    localparam logic [CNT_W:0] H_SS_W    = (CNT_W+1)'(H_ACTIVE) + (CNT_W+1)'(H_FP);
    localparam logic [CNT_W:0] H_SE_W    = H_SS_W + (CNT_W+1)'(H_SYNC) - 1'b1;
    localparam logic [CNT_W:0] V_SS_W    = (CNT_W+1)'(V_ACTIVE) + (CNT_W+1)'(V_FP);
    localparam logic [CNT_W:0] V_SE_W    = V_SS_W + (CNT_W+1)'(V_SYNC) - 1'b1;
    localparam logic [CNT_W:0] CNT_SPAN  = (CNT_W+1)'(1) << CNT_W;

    if (H_TOTAL_W > CNT_SPAN) begin : g_h_total_chk
        $error("vga_sync_gen: H_TOTAL exceeds 2**CNT_W");
    end
    if (V_TOTAL_W > CNT_SPAN) begin : g_v_total_chk
        $error("vga_sync_gen: V_TOTAL exceeds 2**CNT_W");
    end

    logic h_wrap, v_wrap, v_en;
    logic h_active, v_active;
    logic line_start_q, frame_start_q;

    assign v_en = pix_en && h_wrap;

    vga_axis_counter #(
        .CNT_W      (CNT_W),
        .TOTAL      (32'(H_TOTAL_W)),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (32'(H_SS_W)),
        .SYNC_END   (32'(H_SE_W)),
        .SYNC_POL   (SYNC_POL)
    ) u_h (
        .clk_i    (clk),
        .reset_i  (reset),
        .en_i     (pix_en),
        .wrap_o   (h_wrap),
        .pos_o    (x),
        .sync_o   (hsync),
        .active_o (h_active)
    );

    vga_axis_counter #(
        .CNT_W      (CNT_W),
        .TOTAL      (32'(V_TOTAL_W)),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (32'(V_SS_W)),
        .SYNC_END   (32'(V_SE_W)),
        .SYNC_POL   (SYNC_POL)
    ) u_v (
        .clk_i    (clk),
        .reset_i  (reset),
        .en_i     (v_en),
        .wrap_o   (v_wrap),
        .pos_o    (y),
        .sync_o   (vsync),
        .active_o (v_active)
    );

    assign video_on = h_active && v_active;

    // v_wrap already requires the horizontal wrap, so frame_start implies line_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed + randomized bench for vga_sync_gen on a reduced timing so whole
// frames fit in a short run; the reference derives position from strobe count.
module tb_vga_sync_gen;

    localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int unsigned VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned CW = 10;

    logic          clk;
    logic          reset;
    logic          pix_en;
    logic          hsync, vsync, video_on, line_start, frame_start;
    logic [CW-1:0] x, y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // reference state
    int unsigned n        = 0;
    bit          strobed  = 0;
    int unsigned fc       = 0;
    int unsigned since_fs = 0;
    bit          have_fs  = 0;

    vga_sync_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0), .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: got %0d expected %0d (strobes=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        int unsigned pos, h, v;
        bit ehs, evs, evo, els, efs;
        if (n == 0) begin
            h = 0; v = 0; ehs = 1; evs = 1; evo = 0; els = 0; efs = 0;
        end else begin
            pos = (n - 1) % (HT * VT);
            h   = pos % HT;
            v   = pos / HT;
            ehs = !((h >= HA + HF) && (h < HA + HF + HS));
            evs = !((v >= VA + VF) && (v < VA + VF + VS));
            evo = (h < HA) && (v < VA);
            els = strobed && (h == 0);
            efs = els && (v == 0);
        end
        chk("x", 32'(x), h);
        chk("y", 32'(y), v);
        chk("hsync", 32'(hsync), 32'(ehs));
        chk("vsync", 32'(vsync), 32'(evs));
        chk("video_on", 32'(video_on), 32'(evo));
        chk("line_start", 32'(line_start), 32'(els));
        chk("frame_start", 32'(frame_start), 32'(efs));
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), fc % 65536);
`endif
        if (frame_start === 1'b1) begin
            if (have_fs) chk("fs_spacing", since_fs, HT * VT);
            have_fs  = 1;
            since_fs = 0;
        end
    endtask

    task automatic step(input bit r, input bit e);
        reset  = r;
        pix_en = e;
        @(posedge clk);
        if (r) begin
            n = 0; strobed = 0; fc = 0; since_fs = 0; have_fs = 0;
        end else begin
            strobed = e;
            if (e) begin
                n++;
                since_fs++;
                if ((n - 1) % (HT * VT) == 0) fc++;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;

        // reset, including reset winning over pix_en
        step(1, 0);
        step(1, 1);
        step(1, 0);

        // single strobe lands on (0,0) with both start pulses, then they clear
        step(0, 1);
        step(0, 0);
        step(0, 0);

        // one strobe every 4th clk for a little over two lines
        for (int i = 0; i < 4 * (2 * HT + 7); i++) step(0, (i % 4) == 3);

        // pix_en tied high across two full frames
        for (int i = 0; i < 2 * HT * VT + 3; i++) step(0, 1);

        // walk to (10,5) then reset together with pix_en
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (n != 0 && ((n - 1) % (HT * VT)) == 5 * HT + 10) break;
            step(0, 1);
        end
        chk("reach_pos", 32'(x) | (32'(y) << 16), 32'(10) | (32'(5) << 16));
        step(1, 1);
        step(0, 0);
        step(0, 1);

        // randomized strobes with occasional reset
        for (int i = 0; i < 3 * HT * VT * 2; i++) begin
            step($urandom_range(0, 599) == 0, $urandom_range(0, 1) == 1);
        end

        // three clean frames from reset
        step(1, 0);
        for (int i = 0; i < 3 * HT * VT; i++) step(0, 1);
        step(0, 0);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt_3", 32'(frame_cnt), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
